lcd_frame_engine: RTL and testbench

- Display-side end of the game-to-LCD interface: owns the 128x64 monochrome frame buffer (VRAM).
- Accepts word writes and refresh requests from game logic and reports a 2-bit status.
- Runs the ST7565-class panel power-up, then streams VRAM to the panel over the write-only serial link (cs1/rs/sclk/sid/reset).
- Instantiated once under the top level, between game logic and the panel pins.

---
 rtl/lcd_frame_engine.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_lcd_frame_engine.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_engine.sv
// lcd_frame_engine
// Display-side end of the game-to-LCD link. It owns the 128x64 monochrome
// frame buffer, accepts word writes and refresh requests from game logic,
// powers up an ST7565-class panel and streams the buffer to it over the
// write-only serial link.
//
// Ports:
//   clk, rstn        system clock, asynchronous active-low reset
//   I_refresh        level request to push VRAM to the panel
//   I_vram_we        VRAM write enable (honoured in READY/FINISH only)
//   I_row, I_col     VRAM address: pixel line 0..63, 32-bit word 0..3
//   I_data           write data
//   O_data           registered read data of VRAM[I_row][I_col]
//   O_status         0=INIT 1=READY 2=BUSY 3=FINISH
//   O_cs1, O_rs      panel chip select (active low), command/data select
//   O_sclk, O_sid    serial clock (idles high), serial data MSB first
//   O_reset          panel reset, active low
module lcd_frame_engine #(
    parameter int CLK_DIV      = 4,
    parameter int DELAY_MS     = 100000,
    parameter int RESET_MS     = 1,
    parameter int INIT_WAIT_MS = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        I_refresh,
    input  logic        I_vram_we,
    input  logic [6:0]  I_row,
    input  logic [1:0]  I_col,
    input  logic [31:0] I_data,
    output logic [31:0] O_data,
    output logic [1:0]  O_status,
    output logic        O_cs1,
    output logic        O_rs,
    output logic        O_sclk,
    output logic        O_sid,
    output logic        O_reset
);

    localparam logic [31:0] RESET_LAST = 32'(RESET_MS * DELAY_MS - 1);
    localparam logic [31:0] WAIT_LAST  = 32'(INIT_WAIT_MS * DELAY_MS - 1);
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        M_RESET, M_WAIT, M_INIT, M_READY, M_CMD, M_FETCH, M_DATA, M_FINISH
    } main_state_t;

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_GAP} ser_state_t;

    // 64 rows x 4 words; address is {row[5:0], col}
    logic [31:0] vram [0:255];

    main_state_t state, state_next;
    ser_state_t  ser_state;

    logic [31:0] dly_cnt;
    logic [3:0]  cmd_idx;
    logic [2:0]  page;
    logic [6:0]  x_pos;
    logic [2:0]  fetch_k;
    logic [6:0]  asm_bits;
    logic [15:0] div_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic [7:0]  init_cmd;
    logic [7:0]  ser_byte_in;
    logic        ser_start, ser_rs_in, ser_done, ser_ready;
    logic        div_last, dly_last, fetch_bit, wr_ok;

    assign wr_ok     = I_vram_we && !I_row[6] && (state == M_READY || state == M_FINISH);
    assign div_last  = (div_cnt == DIV_LAST);
    assign dly_last  = (state == M_RESET) ? (dly_cnt == RESET_LAST) : (dly_cnt == WAIT_LAST);
    assign ser_done  = (ser_state == S_GAP) && div_last;
    // A new byte may start in the last gap cycle so bytes run back to back
    assign ser_ready = (ser_state == S_IDLE) || ser_done;
    // Pixel (x, 8*page+k): leftmost pixel of a word is its bit 31
    assign fetch_bit = vram[{page, fetch_k, x_pos[6:5]}][~x_pos[4:0]];

    always_comb begin
        case (cmd_idx[2:0])
            3'd0:    init_cmd = 8'hA2;
            3'd1:    init_cmd = 8'hA0;
            3'd2:    init_cmd = 8'hC8;
            3'd3:    init_cmd = 8'h2F;
            3'd4:    init_cmd = 8'h26;
            3'd5:    init_cmd = 8'h81;
            3'd6:    init_cmd = 8'h10;
            default: init_cmd = 8'hAF;
        endcase
    end

    always_comb begin
        case (state)
            M_RESET, M_WAIT, M_INIT: O_status = 2'd0;
            M_READY:                 O_status = 2'd1;
            M_FINISH:                O_status = 2'd3;
            default:                 O_status = 2'd2;
        endcase
    end

    // Frame buffer write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_ok)
            vram[{I_row[5:0], I_col}] <= I_data;
    end

    // Registered read port; same-address write returns the old word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            O_data <= 32'd0;
        else
            O_data <= I_row[6] ? 32'd0 : vram[{I_row[5:0], I_col}];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= M_RESET;
        else
            state <= state_next;
    end

    // Sequencer: power-up timing, init commands, page/column walk.
    // The first init command is launched in the last wait cycle so the
    // wait is exactly INIT_WAIT_MS long before cs1 falls.
    always_comb begin
        state_next  = state;
        ser_start   = 1'b0;
        ser_byte_in = 8'h00;
        ser_rs_in   = 1'b0;
        case (state)
            M_RESET: if (dly_last) state_next = M_WAIT;
            M_WAIT: begin
                if (dly_last) begin
                    ser_start   = 1'b1;
                    ser_byte_in = init_cmd;
                    state_next  = M_INIT;
                end
            end
            M_INIT: begin
                if (ser_ready) begin
                    if (cmd_idx < 4'd8) begin
                        ser_start   = 1'b1;
                        ser_byte_in = init_cmd;
                    end else begin
                        state_next = M_READY;
                    end
                end
            end
            M_READY: if (I_refresh) state_next = M_CMD;
            M_CMD: begin
                if (ser_ready) begin
                    if (cmd_idx < 4'd3) begin
                        ser_start = 1'b1;
                        case (cmd_idx[1:0])
                            2'd0:    ser_byte_in = {5'b10110, page};
                            2'd1:    ser_byte_in = 8'h10;
                            default: ser_byte_in = 8'h00;
                        endcase
                    end else begin
                        state_next = M_FETCH;
                    end
                end
            end
            M_FETCH: begin
                if (fetch_k == 3'd7) begin
                    ser_start   = 1'b1;
                    ser_byte_in = {fetch_bit, asm_bits};
                    ser_rs_in   = 1'b1;
                    state_next  = M_DATA;
                end
            end
            M_DATA: begin
                if (ser_done) begin
                    if (x_pos == 7'd127)
                        state_next = (page == 3'd7) ? M_FINISH : M_CMD;
                    else
                        state_next = M_FETCH;
                end
            end
            M_FINISH: if (!I_refresh) state_next = M_READY;
            default:  state_next = M_RESET;
        endcase
    end

    // Delay, command and pixel-walk counters plus the panel reset pin
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dly_cnt  <= 32'd0;
            cmd_idx  <= 4'd0;
            page     <= 3'd0;
            x_pos    <= 7'd0;
            fetch_k  <= 3'd0;
            asm_bits <= 7'd0;
            O_reset  <= 1'b0;
        end else begin
            case (state)
                M_RESET, M_WAIT: begin
                    if (dly_last) begin
                        dly_cnt <= 32'd0;
                        O_reset <= 1'b1;
                        if (state == M_WAIT)
                            cmd_idx <= 4'd1;
                    end else begin
                        dly_cnt <= dly_cnt + 32'd1;
                    end
                end
                M_INIT, M_CMD: if (ser_start) cmd_idx <= cmd_idx + 4'd1;
                M_READY: begin
                    cmd_idx <= 4'd0;
                    page    <= 3'd0;
                    x_pos   <= 7'd0;
                    fetch_k <= 3'd0;
                end
                M_FETCH: begin
                    // Rows 8p..8p+6 shift down so row 8p lands in bit 0
                    asm_bits <= {fetch_bit, asm_bits[6:1]};
                    fetch_k  <= fetch_k + 3'd1;
                end
                M_DATA: begin
                    if (ser_done) begin
                        x_pos <= x_pos + 7'd1;
                        if (x_pos == 7'd127) begin
                            page    <= page + 3'd1;
                            cmd_idx <= 4'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte serializer: cs1 low for 8 bits of (sclk low, sclk high),
    // then a cs1-high gap; each phase lasts CLK_DIV cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ser_state <= S_IDLE;
            div_cnt   <= 16'd0;
            bit_cnt   <= 3'd0;
            shift     <= 8'd0;
            O_cs1     <= 1'b1;
            O_rs      <= 1'b0;
            O_sclk    <= 1'b1;
            O_sid     <= 1'b0;
        end else if (ser_start) begin
            ser_state <= S_LOW;
            div_cnt   <= 16'd0;
            bit_cnt   <= 3'd7;
            shift     <= {ser_byte_in[6:0], 1'b0};
            O_cs1     <= 1'b0;
            O_sclk    <= 1'b0;
            O_sid     <= ser_byte_in[7];
            O_rs      <= ser_rs_in;
        end else begin
            case (ser_state)
                S_LOW: begin
                    if (div_last) begin
                        ser_state <= S_HIGH;
                        div_cnt   <= 16'd0;
                        O_sclk    <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                S_HIGH: begin
                    if (div_last) begin
                        div_cnt <= 16'd0;
                        if (bit_cnt == 3'd0) begin
                            ser_state <= S_GAP;
                            O_cs1     <= 1'b1;
                        end else begin
                            ser_state <= S_LOW;
                            O_sclk    <= 1'b0;
                            O_sid     <= shift[7];
                            shift     <= {shift[6:0], 1'b0};
                            bit_cnt   <= bit_cnt - 3'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (div_last) begin
                        ser_state <= S_IDLE;
                        div_cnt   <= 16'd0;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_engine.sv
// tb_lcd_frame_engine
// Self-checking bench for lcd_frame_engine with a short power-up timing.
// A serial decoder rebuilds every byte sent on cs1/sclk/sid/rs and the
// expected byte streams are computed from a pixel-level model of VRAM.
module tb_lcd_frame_engine;

    localparam int CLK_DIV      = 1;
    localparam int DELAY_MS     = 10;
    localparam int RESET_MS     = 1;
    localparam int INIT_WAIT_MS = 5;
    localparam int BYTES_PER_PAGE = 131;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        I_refresh = 1'b0;
    logic        I_vram_we = 1'b0;
    logic [6:0]  I_row = 7'd0;
    logic [1:0]  I_col = 2'd0;
    logic [31:0] I_data = 32'd0;
    logic [31:0] O_data;
    logic [1:0]  O_status;
    logic        O_cs1, O_rs, O_sclk, O_sid, O_reset;

    int tests = 0;
    int fails = 0;

    logic [31:0] model [64][4];
    logic [8:0]  cap_q [$];
    logic [8:0]  exp_q [$];
    logic [7:0]  init_seq [8] = '{8'hA2, 8'hA0, 8'hC8, 8'h2F, 8'h26, 8'h81, 8'h10, 8'hAF};

    int          dec_n = 0;
    logic [7:0]  dec_byte = 8'd0;
    logic        dec_rs = 1'b0;
    int          rs_bad = 0;
    int          sclk_edges = 0;
    int          cs1_run = 0;
    int          cs1_bad = 0;
    int          cs1_runs = 0;

    lcd_frame_engine #(
        .CLK_DIV(CLK_DIV), .DELAY_MS(DELAY_MS),
        .RESET_MS(RESET_MS), .INIT_WAIT_MS(INIT_WAIT_MS)
    ) dut (
        .clk(clk), .rstn(rstn), .I_refresh(I_refresh), .I_vram_we(I_vram_we),
        .I_row(I_row), .I_col(I_col), .I_data(I_data), .O_data(O_data),
        .O_status(O_status), .O_cs1(O_cs1), .O_rs(O_rs), .O_sclk(O_sclk),
        .O_sid(O_sid), .O_reset(O_reset)
    );

    always #5 clk = ~clk;

    // Serial decoder: shift sid on rising sclk while cs1 is low
    always @(posedge O_sclk or negedge rstn) begin
        if (!rstn) begin
            dec_n    = 0;
            dec_byte = 8'd0;
        end else begin
            sclk_edges++;
            if (!O_cs1) begin
                if (dec_n == 0)
                    dec_rs = O_rs;
                else if (O_rs !== dec_rs)
                    rs_bad++;
                dec_byte = {dec_byte[6:0], O_sid};
                dec_n++;
                if (dec_n == 8) begin
                    cap_q.push_back({dec_rs, dec_byte});
                    dec_n = 0;
                end
            end
        end
    end

    // Every byte must hold cs1 low for exactly 16 half-periods
    always @(negedge clk) begin
        if (!rstn) begin
            cs1_run = 0;
        end else if (O_cs1 === 1'b0) begin
            cs1_run++;
        end else if (cs1_run > 0) begin
            if (cs1_run != 16 * CLK_DIV)
                cs1_bad++;
            cs1_runs++;
            cs1_run = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of a VRAM access; returns at the next falling edge
    task automatic applyStimulus(input logic we, input logic [6:0] row,
                                 input logic [1:0] col, input logic [31:0] data);
        I_vram_we = we;
        I_row     = row;
        I_col     = col;
        I_data    = data;
        @(negedge clk);
        I_vram_we = 1'b0;
    endtask

    task automatic readCheck(input logic [6:0] row, input logic [1:0] col,
                             input logic [31:0] exp, input string tag);
        I_row = row;
        I_col = col;
        @(negedge clk);
        checkOutput(tag, O_data, exp);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_status"}, 32'(O_status), 32'd0);
        checkOutput({tag, "_cs1"},    32'(O_cs1),    32'd1);
        checkOutput({tag, "_rs"},     32'(O_rs),     32'd0);
        checkOutput({tag, "_sclk"},   32'(O_sclk),   32'd1);
        checkOutput({tag, "_sid"},    32'(O_sid),    32'd0);
        checkOutput({tag, "_reset"},  32'(O_reset),  32'd0);
        checkOutput({tag, "_data"},   O_data,        32'd0);
    endtask

    task automatic waitStatus(input logic [1:0] want, input int budget, input string tag);
        int guard = 0;
        while (O_status !== want && guard < budget) begin
            @(negedge clk);
            guard++;
        end
        checkOutput(tag, 32'(O_status), 32'(want));
    endtask

    // Release reset and check panel reset timing and the init command list
    task automatic runInit(input string tag);
        int n;
        int guard;
        int bad;
        cap_q.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        n = 0;
        guard = 0;
        while (O_reset === 1'b0 && guard < 1000) begin
            n++;
            guard++;
            @(negedge clk);
        end
        checkOutput({tag, "_reset_low_cycles"}, n, RESET_MS * DELAY_MS);
        n = 0;
        guard = 0;
        while (O_reset === 1'b1 && O_cs1 === 1'b1 && guard < 1000) begin
            n++;
            guard++;
            @(negedge clk);
        end
        checkOutput({tag, "_init_wait_cycles"}, n, INIT_WAIT_MS * DELAY_MS);
        checkOutput({tag, "_status_init"}, 32'(O_status), 32'd0);
        waitStatus(2'd1, 2000, {tag, "_status_ready"});
        checkOutput({tag, "_init_byte_count"}, cap_q.size(), 8);
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (i >= cap_q.size() || cap_q[i] !== {1'b0, init_seq[i]})
                bad++;
        checkOutput({tag, "_init_bytes_bad"}, bad, 0);
    endtask

    // Expected stream: page address commands, then one byte per column
    // whose bit k is the pixel on line 8p+k, read from the VRAM model
    task automatic buildExpected();
        logic [7:0] b;
        exp_q.delete();
        for (int p = 0; p < 8; p++) begin
            exp_q.push_back({1'b0, 8'hB0 | 8'(p)});
            exp_q.push_back({1'b0, 8'h10});
            exp_q.push_back({1'b0, 8'h00});
            for (int x = 0; x < 128; x++) begin
                for (int k = 0; k < 8; k++)
                    b[k] = model[8 * p + k][x / 32][31 - (x % 32)];
                exp_q.push_back({1'b1, b});
            end
        end
    endtask

    task automatic compareStream(input string tag);
        int bad;
        checkOutput({tag, "_byte_count"}, cap_q.size(), exp_q.size());
        for (int p = 0; p < 8; p++) begin
            bad = 0;
            for (int i = p * BYTES_PER_PAGE; i < (p + 1) * BYTES_PER_PAGE; i++)
                if (i >= cap_q.size() || cap_q[i] !== exp_q[i])
                    bad++;
            checkOutput($sformatf("%s_page%0d_bad_bytes", tag, p), bad, 0);
        end
    endtask

    initial begin
        int bad;
        int e0;
        int guard;
        logic [6:0]  row, rrow;
        logic [1:0]  col, rcol;
        logic [31:0] data;

        #1 rstn = 1'b0;
        #10 checkReset("por");
        runInit("boot");

        // Reference image: top half has the left 16 pixels of each word lit
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 4; c++) begin
                data = (r < 32) ? 32'hFFFF0000 : 32'h0;
                applyStimulus(1'b1, 7'(r), 2'(c), data);
                model[r][c] = data;
            end

        applyStimulus(1'b1, 7'd70, 2'd1, 32'hA5A5A5A5);
        readCheck(7'd70, 2'd1, 32'd0, "row70_read_zero");
        readCheck(7'd6, 2'd1, 32'hFFFF0000, "row70_no_alias");

        applyStimulus(1'b1, 7'd5, 2'd2, 32'hDEADBEEF);
        readCheck(7'd5, 2'd2, 32'hDEADBEEF, "read_deadbeef");
        applyStimulus(1'b1, 7'd5, 2'd2, 32'h12345678);
        checkOutput("read_during_write_old", O_data, 32'hDEADBEEF);
        readCheck(7'd5, 2'd2, 32'h12345678, "read_after_write_new");
        applyStimulus(1'b1, 7'd5, 2'd2, 32'hFFFF0000);

        // First refresh checked against the stripe pattern directly
        exp_q.delete();
        for (int p = 0; p < 8; p++) begin
            exp_q.push_back({1'b0, 8'hB0 | 8'(p)});
            exp_q.push_back({1'b0, 8'h10});
            exp_q.push_back({1'b0, 8'h00});
            for (int x = 0; x < 128; x++)
                exp_q.push_back({1'b1, (p < 4 && (x % 32) < 16) ? 8'hFF : 8'h00});
        end
        cap_q.delete();
        checkOutput("status_ready_before_refresh", 32'(O_status), 32'd1);
        I_refresh = 1'b1;
        @(negedge clk);
        checkOutput("status_busy", 32'(O_status), 32'd2);
        repeat (500) @(negedge clk);
        for (int c = 0; c < 4; c++)
            applyStimulus(1'b1, 7'd0, 2'(c), 32'd0);
        checkOutput("status_busy_mid", 32'(O_status), 32'd2);
        waitStatus(2'd3, 40000, "status_finish1");
        compareStream("refresh1");

        e0 = sclk_edges;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (O_status !== 2'd3)
                bad++;
        end
        checkOutput("finish_hold_status_bad", bad, 0);
        checkOutput("finish_hold_sclk_edges", sclk_edges - e0, 0);
        I_refresh = 1'b0;
        @(negedge clk);
        checkOutput("status_ready_after_drop", 32'(O_status), 32'd1);
        readCheck(7'd0, 2'd0, 32'hFFFF0000, "busy_write_ignored");

        // Random traffic below the stripe band, plus out-of-range rows
        repeat (20) begin
            row  = 7'($urandom_range(127, 32));
            col  = 2'($urandom_range(3, 0));
            data = $urandom;
            applyStimulus(1'b1, row, col, data);
            if (row < 64)
                model[row][col] = data;
            readCheck(row, col, (row < 64) ? model[row][col] : 32'd0, "rand_write_readback");
            rrow = 7'($urandom_range(127, 0));
            rcol = 2'($urandom_range(3, 0));
            readCheck(rrow, rcol, (rrow < 64) ? model[rrow][rcol] : 32'd0, "rand_read");
        end

        // Second refresh against the model; dropping the request mid-way must not abort
        buildExpected();
        cap_q.delete();
        I_refresh = 1'b1;
        repeat (2000) @(negedge clk);
        I_refresh = 1'b0;
        checkOutput("refresh_drop_no_abort", 32'(O_status), 32'd2);
        waitStatus(2'd3, 40000, "status_finish2");
        @(negedge clk);
        checkOutput("status_ready_after_finish2", 32'(O_status), 32'd1);
        compareStream("refresh2");

        // Third refresh interrupted by reset while page 3 is streaming
        cap_q.delete();
        I_refresh = 1'b1;
        guard = 0;
        while (cap_q.size() < 3 * BYTES_PER_PAGE + 7 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reached_page3", 32'(cap_q.size() >= 3 * BYTES_PER_PAGE + 7), 32'd1);
        checkOutput("midbusy_status", 32'(O_status), 32'd2);
        #2 rstn = 1'b0;
        #1 checkReset("midbusy");
        I_refresh = 1'b0;
        repeat (3) @(negedge clk);
        runInit("rerun");
        readCheck(7'd0, 2'd0, 32'hFFFF0000, "retained_row0");
        repeat (6) begin
            rrow = 7'($urandom_range(63, 0));
            rcol = 2'($urandom_range(3, 0));
            readCheck(rrow, rcol, model[rrow][rcol], "retained_rand");
        end

        checkOutput("cs1_low_run_bad", cs1_bad, 0);
        checkOutput("cs1_runs_seen", 32'(cs1_runs > 2000), 32'd1);
        checkOutput("rs_unstable_bits", rs_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
